// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the PC, issues one word read at a time to
// instruction memory, buffers returned words in a small prefetch queue
// and presents them to execute on a valid/ready interface.
// A redirect loads a new PC, flushes the queue and drops any in-flight read.
//
// Optional build macro FETCH_PERF_EN adds the stall_cnt output, which counts
// cycles with no instruction available to execute.
//
// FSM states:
//   state  | meaning
//   S_IDLE | no request issued; waiting for a free queue slot
//   S_REQ  | request at imem_addr (== pc) outstanding; data is kept on ack
//   S_DROP | request at an old address outstanding; data is discarded on ack

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   pc;
    logic          req_q;
    logic [31:0]   addr_q;

    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          ack_hit;
    logic          push;
    logic          pop;
    logic [CW-1:0] cnt_after;
    logic [31:0]   pc_plus4;
    logic [31:0]   redirect_tgt;
    logic          unused_rpc_lsb;

    // The low two bits of the redirect target are deliberately ignored.
    assign unused_rpc_lsb = ^redirect_pc[1:0];
    assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
    assign pc_plus4       = pc + 32'd4;

    // An ack only counts while a request is actually outstanding, so a
    // stray ack after reset or in IDLE has no effect.
    assign ack_hit     = imem_ack && req_q;
    assign push        = ack_hit && (state == S_REQ) && !redirect;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign instr     = instr_valid ? q_instr[head] : 32'd0;
    assign instr_pc  = instr_valid ? q_pc[head]    : 32'd0;

    // Occupancy after this cycle's push and pop (redirect handled separately).
    always_comb begin
        cnt_after = count;
        if (push && !pop) begin
            cnt_after = count + CW'(1);
        end else if (pop && !push) begin
            cnt_after = count - CW'(1);
        end
    end

    // Fetch FSM: owns pc, imem_req and the registered request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            req_q  <= 1'b0;
            addr_q <= 32'd0;
        end else if (redirect) begin
            pc <= redirect_tgt;
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        state  <= S_REQ;
                        addr_q <= redirect_tgt;
                    end else begin
                        // Address must stay stable until the old read completes.
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state  <= S_REQ;
                        addr_q <= redirect_tgt;
                    end
                end
                default: begin
                    state  <= S_REQ;
                    req_q  <= 1'b1;
                    addr_q <= redirect_tgt;
                end
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (count < DEPTH_C) begin
                        state  <= S_REQ;
                        req_q  <= 1'b1;
                        addr_q <= pc;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        pc <= pc_plus4;
                        if (cnt_after < DEPTH_C) begin
                            addr_q <= pc_plus4;
                        end else begin
                            state <= S_IDLE;
                            req_q <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state  <= S_REQ;
                        addr_q <= pc;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= cnt_after;
        end
    end

    // Queue storage; entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= imem_rdata;
            q_pc[tail]    <= addr_q;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating count of cycles with nothing to hand to execute.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (!instr_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against a queue-level reference model of the fetch stream.

module tb_instr_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] w_stall_unused;
`endif

    logic        w_rst;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic        w_valid;
    logic        w_ready;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;

    int checks = 0;
    int errors = 0;

    // reference model: words delivered but not yet consumed, next expected fetch
    logic [31:0] mq_pc[$];
    logic [31:0] mq_data[$];
    logic [31:0] m_next;
    bit          m_stale;
    int          pops;
    bit          prev_req;
    bit          prev_ack;
    logic [31:0] prev_addr;

    instr_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
        .clk(clk), .rst(w_rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .instr(w_instr), .instr_pc(w_instr_pc),
        .instr_valid(w_valid), .instr_ready(w_ready),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc)
`ifdef FETCH_PERF_EN
        , .stall_cnt(w_stall_unused)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        mq_pc.delete();
        mq_data.delete();
        m_next   = RPC;
        m_stale  = 1'b0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = 32'd0;
    endtask

    // Drive one cycle of memory/execute/redirect stimulus and advance the model.
    task automatic step(input bit ack_i, input bit ready_i, input bit redir_i,
                        input logic [31:0] rpc_i);
        bit ackd;
        ackd        = ack_i && (imem_req === 1'b1);
        imem_ack    = ackd;
        imem_rdata  = ackd ? word_of(imem_addr) : $urandom;
        instr_ready = ready_i;
        redirect    = redir_i;
        redirect_pc = rpc_i;
        if (redir_i) begin
            mq_pc.delete();
            mq_data.delete();
            m_next  = {rpc_i[31:2], 2'b00};
            m_stale = (imem_req === 1'b1) && !ackd;
        end else begin
            if (mq_pc.size() != 0 && ready_i) begin
                void'(mq_pc.pop_front());
                void'(mq_data.pop_front());
                pops++;
            end
            if (ackd) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    mq_pc.push_back(m_next);
                    mq_data.push_back(word_of(m_next));
                    m_next = m_next + 32'd4;
                end
            end
        end
        prev_req  = (imem_req === 1'b1);
        prev_ack  = ackd;
        prev_addr = imem_addr;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        checks++; if (instr !== 32'd0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
        checks++; if (instr_pc !== 32'd0) begin errors++; $display("FAIL rst_instr_pc got %h exp 0", instr_pc); end
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL first_addr got %h exp %h", imem_addr, RPC); end
        // reset in the middle of the request, then a late ack
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midreq_rst_req got %b exp 0", imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL late_ack_valid got %b exp 0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            errors++; $display("FAIL late_ack_req got %b/%h exp 1/%h", imem_req, imem_addr, RPC);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = 32'(i * 4);
            checks++; if (imem_req !== 1'b1 || imem_addr !== exp) begin
                errors++; $display("FAIL stream_addr%0d got %b/%h exp 1/%h", i, imem_req, imem_addr, exp);
            end
            step(1'b1, 1'b1, 1'b0, 32'd0);
            checks++; if (instr_valid !== 1'b1 || instr_pc !== exp) begin
                errors++; $display("FAIL stream_pc%0d got %b/%h exp 1/%h", i, instr_valid, instr_pc, exp);
            end
            checks++; if (instr !== word_of(exp)) begin
                errors++; $display("FAIL stream_instr%0d got %h exp %h", i, instr, word_of(exp));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req got %b exp 0", imem_req); end
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_idle_req got %b exp 0", imem_req); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++; $display("FAIL bp_head0 got %b/%h exp 1/0", instr_valid, instr_pc);
        end
        step(1'b0, 1'b1, 1'b0, 32'd0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== word_of(32'h4)) begin
            errors++; $display("FAIL bp_head4 got %b/%h/%h exp 1/4/%h", instr_valid, instr_pc, instr, word_of(32'h4));
        end
        step(1'b0, 1'b1, 1'b0, 32'd0);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL bp_resume got %b/%h exp 1/8", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_outstanding();
        do_reset();
        step(1'b0, 1'b1, 1'b1, 32'h10);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            errors++; $display("FAIL rdo_req got %b/%h exp 1/10", imem_req, imem_addr);
        end
        step(1'b0, 1'b1, 1'b1, 32'h103);
        for (int i = 0; i < 2; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL rdo_hold%0d got %b/%h/%b exp 1/10/0", i, imem_req, imem_addr, instr_valid);
            end
            step(1'b0, 1'b1, 1'b0, 32'd0);
        end
        step(1'b1, 1'b1, 1'b0, 32'd0);
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL rdo_drop got %b/%b/%h exp 0/1/100", instr_valid, imem_req, imem_addr);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== word_of(32'h100)) begin
            errors++; $display("FAIL rdo_new got %b/%h/%h exp 1/100/%h", instr_valid, instr_pc, instr, word_of(32'h100));
        end
    endtask

    task automatic test_redirect_ack_pop();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++; $display("FAIL rap_one got %b/%h exp 1/0", instr_valid, instr_pc);
        end
        step(1'b1, 1'b1, 1'b1, 32'h200);
        checks++; if (instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 32'd0) begin
            errors++; $display("FAIL rap_flush got %b/%h/%h exp 0/0/0", instr_valid, instr, instr_pc);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL rap_addr got %b/%h exp 1/200", imem_req, imem_addr);
        end
        step(1'b1, 1'b1, 1'b0, 32'd0);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
            errors++; $display("FAIL rap_new got %b/%h exp 1/200", instr_valid, instr_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got [3];
        logic [31:0] exp [3];
        int n;
        exp[0] = 32'hFFFF_FFF8; exp[1] = 32'hFFFF_FFFC; exp[2] = 32'h0000_0000;
        w_rst = 1'b1; w_ack = 1'b0; w_ready = 1'b1; w_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        w_rst = 1'b0;
        n = 0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            w_ack = w_req;
            w_rdata = word_of(w_addr);
            if (w_req) begin
                got[n] = w_addr;
                n++;
            end
            @(posedge clk); @(negedge clk);
        end
        w_ack = 1'b0;
        checks++; if (n != 3) begin errors++; $display("FAIL wrap_count got %0d exp 3", n); end
        for (int i = 0; i < 3; i++) begin
            if (i < n) begin
                checks++; if (got[i] !== exp[i]) begin
                    errors++; $display("FAIL wrap_addr%0d got %h exp %h", i, got[i], exp[i]);
                end
            end
        end
        checks++; if (w_valid !== 1'b1 || w_instr_pc !== 32'h0 || w_instr !== word_of(32'h0)) begin
            errors++; $display("FAIL wrap_head got %b/%h/%h exp 1/0/%h", w_valid, w_instr_pc, w_instr, word_of(32'h0));
        end
    endtask

    task automatic test_random();
        bit          ack, rdy, rd;
        logic [31:0] rpc;
        bit          exp_v;
        logic [31:0] exp_pc, exp_d;
        do_reset();
        pops = 0;
        for (int c = 0; c < 3000; c++) begin
            ack = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 70);
            rd  = ($urandom_range(0, 99) < 4);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step(ack, rdy, rd, rpc);
            exp_v  = (mq_pc.size() != 0);
            exp_pc = exp_v ? mq_pc[0] : 32'd0;
            exp_d  = exp_v ? mq_data[0] : 32'd0;
            checks++; if (instr_valid !== exp_v) begin
                errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, instr_valid, exp_v);
            end
            checks++; if (instr_pc !== exp_pc) begin
                errors++; $display("FAIL rnd_pc c%0d got %h exp %h", c, instr_pc, exp_pc);
            end
            checks++; if (instr !== exp_d) begin
                errors++; $display("FAIL rnd_instr c%0d got %h exp %h", c, instr, exp_d);
            end
            checks++; if (imem_addr[1:0] !== 2'b00) begin
                errors++; $display("FAIL rnd_align c%0d got %h exp low bits 00", c, imem_addr);
            end
            checks++; if (mq_pc.size() > DEPTH) begin
                errors++; $display("FAIL rnd_overfetch c%0d got %0d exp <= %0d", c, mq_pc.size(), DEPTH);
            end
            if (prev_req && !prev_ack) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    errors++; $display("FAIL rnd_hold c%0d got %b/%h exp 1/%h", c, imem_req, imem_addr, prev_addr);
                end
            end
        end
        checks++; if (pops < 500) begin errors++; $display("FAIL rnd_progress got %0d exp >= 500", pops); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_rst got %0d exp 0", stall_cnt); end
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'd0);
        checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_5 got %0d exp 5", stall_cnt); end
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++; if (stall_cnt !== 32'd6) begin errors++; $display("FAIL perf_6 got %0d exp 6", stall_cnt); end
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
        checks++; if (stall_cnt !== 32'd6) begin errors++; $display("FAIL perf_hold got %0d exp 6", stall_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'd0;
        w_rst = 1'b1; w_ack = 1'b0; w_rdata = 32'd0; w_ready = 1'b0;
        w_redirect = 1'b0; w_redirect_pc = 32'd0;
        pops = 0;
        model_reset();
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_ack_pop();
        test_wrap();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
